sync_fifo_ctrl: RTL and testbench
=================================

# sync_fifo_ctrl

Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and selectable read mode (registered or first-word-fall-through). It is the DUT that sits behind `fifo_intf`. The write-side driver, read-side slave driver and monitor all connect to it through their existing clocking blocks. Extra status pins are observed by the monitor.

## Interface
- `FIFO_WIDTH`, 32, data word width in bits, ≥1
- `FIFO_DEPTH`, 32, number of entries; power of two, ≥4
- `AF_THRESH`, `FIFO_DEPTH-4`, `almost_full` asserts when count ≥ this value; legal range 1..`FIFO_DEPTH`
- `AE_THRESH`, 4, `almost_empty` asserts when count ≤ this value; legal range 0..`FIFO_DEPTH-1`
- `FWFT`, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rstN`  in  1  reset, asynchronous assert, active-low
- `wr_en`  in  1  write request
- `data_in`  in  `FIFO_WIDTH`  write data
- `rd_en`  in  1  read (pop) request
- `clr_err`  in  1  single-cycle pulse that clears the sticky error flags
- `data_out`  out  `FIFO_WIDTH`  read data
- `empty`  out  1  count == 0
- `full`  out  1  count == `FIFO_DEPTH`
- `almost_full`  out  1  count ≥ `AF_THRESH`
- `almost_empty`  out  1  count ≤ `AE_THRESH`
- `count`  out  `$clog2(FIFO_DEPTH)+1`  current occupancy
- `overflow`  out  1  sticky: a write was attempted while full
- `underflow`  out  1  sticky: a read was attempted while empty

## Operation
- **Reset values** (rstN low):
  - pointers = 0, `count` = 0
  - `empty` = 1, `full` = 0, `almost_empty` = 1
  - `almost_full` = 0 (1 only if `AF_THRESH` = 0, which is illegal)
  - `overflow` = 0, `underflow` = 0, `data_out` = 0
  - Memory contents are not reset.
- **Acceptance** is decided on pre-edge state:
  - A write is accepted iff `wr_en && !full`.
  - A read is accepted iff `rd_en && !empty`.
- **Simultaneous requests:**
  - Full with `wr_en` and `rd_en`: the read is accepted and the write is dropped. `count` becomes `FIFO_DEPTH-1` and `overflow` sets.
  - Empty with `wr_en` and `rd_en`: the write is accepted and the read is rejected. `count` becomes 1 and `underflow` sets.
  - Otherwise, both accepted leaves `count` unchanged, with both pointers advancing.
- **Pointers:** `ADDR_W` = `$clog2(FIFO_DEPTH)`. Each pointer increments modulo `FIFO_DEPTH` and wraps from `FIFO_DEPTH-1` to 0 with no gap.
- **Count update:** `count_next` = `count` + `wr_acc` − `rd_acc`.
- **Flags:** all four are registered and computed from `count_next`, so they change on the same edge as `count`.
- **Error flags:**
  - A rejected request sets the corresponding flag on the next edge. The flag holds until `clr_err` or reset.
  - If `clr_err` coincides with a new error, the flag stays set (set wins).
- **FWFT=0:** on an accepted read, `data_out` loads the head word at the edge. Otherwise `data_out` holds its value.
- **FWFT=1:** `data_out` continuously shows the head word while `!empty`, and shows 0 while empty. An accepted read advances to the next word.

## Timing
- **Write to empty deassert:** 1 cycle. `empty` falls on the edge that accepts the first write.
- **FWFT=0 read latency:** 1 cycle. The word is on `data_out` after the edge that accepts `rd_en`.
- **FWFT=1 first-word visibility:** the first written word appears on `data_out` after the write edge plus combinational read delay. No extra cycle.
- **Throughput:** one write and one read per cycle sustained, with no bubbles at pointer wrap.
- **Reset mid-operation:** all outputs reach their reset values asynchronously. The first accepted access after release is the first write at address 0.
- **Write-through:** none. A word written in cycle N is not readable before cycle N+1.

## Structure
- **Package `fifo_pkg`:**
  - `FIFO_WIDTH_DEF` / `FIFO_DEPTH_DEF` defaults
  - `rd_mode_e` enum (`RD_REG`, `RD_FWFT`)
  - a helper function for `ADDR_W` / count width
- **Sub-module `fifo_mem`:** a simple dual-port array with one synchronous write port and an asynchronous read port.
  - The `FWFT=0` path adds the output register in `sync_fifo_ctrl`.
  - Control, pointers, count, flags and errors live in `sync_fifo_ctrl`.
- **Assertion:** an elaboration-time assertion checks that `FIFO_DEPTH` is a power of two and that thresholds are in range.

## Test plan
- **Reset then idle:** hold rstN low for 3 cycles, release → `empty`=1, `almost_empty`=1, `count`=0, `data_out`=0, error flags 0.
- **Fill to full (DEPTH=32, AF_THRESH=28):** write 0..31 →
  - `almost_full` rises on the edge where `count` becomes 28
  - `full`=1 at `count`=32
  - a 33rd write sets `overflow`; `count` stays 32
- **Drain, FWFT=0:** read 32 times → `data_out` = 0..31 in order, each one cycle after `rd_en`. `empty`=1 after the last read. An extra `rd_en` sets `underflow`.
- **Wrap and concurrency:**
  - write 20, read 20, write 20, read 20 → data intact across pointer wrap
  - simultaneous wr/rd at `count`=10 for 50 cycles → `count` stays 10
- **Full/empty with simultaneous requests:**
  - full + `wr_en` + `rd_en` → `count`=31, `overflow`=1
  - empty + both → `count`=1, `underflow`=1
  - `clr_err` coinciding with a new overflow → `overflow` stays 1
- **FWFT=1:** single write of 0xA5A5_0001 → visible on `data_out` with `empty`=0 before any `rd_en`. `rd_en` → `empty`=1 and `data_out`=0. Assert rstN mid-stream → immediate reset values.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the synchronous FIFO controller.
//   FIFO_WIDTH_DEF / FIFO_DEPTH_DEF : default word width and depth
//   rd_mode_e                       : read mode encoding (registered / FWFT)
//   addr_width / cnt_width          : pointer width and occupancy-count width
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 32;
    localparam int FIFO_DEPTH_DEF = 32;

    typedef enum logic {
        RD_REG  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that a completely full FIFO (count == depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage array for the FIFO.
//   clk      : write clock
//   wr_en    : write strobe, stores wr_data at wr_addr on the rising edge
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : asynchronous read data (mem[rd_addr])
// Contents are deliberately not reset.
module fifo_mem #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_array [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_array[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with occupancy count, almost-full /
// almost-empty thresholds, sticky overflow/underflow flags and selectable
// read mode (FWFT = 0 registered read, FWFT = 1 first-word-fall-through).
//   clk, rstN      : clock, asynchronous active-low reset
//   wr_en, data_in : write request and data
//   rd_en          : read (pop) request
//   clr_err        : pulse clearing the sticky error flags
//   data_out       : read data
//   empty, full, almost_full, almost_empty, count : occupancy status
//   overflow, underflow : sticky error flags
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int AF_THRESH  = FIFO_DEPTH - 4,
    parameter int AE_THRESH  = 4,
    parameter int FWFT       = 0
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic                             wr_en,
    input  logic [FIFO_WIDTH-1:0]            data_in,
    input  logic                             rd_en,
    input  logic                             clr_err,
    output logic [FIFO_WIDTH-1:0]            data_out,
    output logic                             empty,
    output logic                             full,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic [cnt_width(FIFO_DEPTH)-1:0] count,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int ADDR_W = addr_width(FIFO_DEPTH);
    localparam int CNT_W  = cnt_width(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    // Parameter legality is checked at elaboration.
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_ctrl: FIFO_DEPTH must be a power of two and at least 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
        $error("sync_fifo_ctrl: AF_THRESH out of range 1..FIFO_DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_ctrl: AE_THRESH out of range 0..FIFO_DEPTH-1");
    end
    if (FIFO_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_ctrl: FIFO_WIDTH must be at least 1");
    end

    logic [ADDR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  empty_reg, full_reg, almost_full_reg, almost_empty_reg;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic                  wr_acc, rd_acc;
    logic [FIFO_WIDTH-1:0] rd_data;

    // Acceptance uses the registered (pre-edge) flags, so a full FIFO drops
    // a write even when a read is accepted on the same edge, and vice versa.
    assign wr_acc = wr_en && !full_reg;
    assign rd_acc = rd_en && !empty_reg;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        // Power-of-two depth: natural pointer overflow is the modulo wrap.
        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        // A new error takes priority over a coincident clear.
        if (wr_en && full_reg) begin
            overflow_next = 1'b1;
        end else if (clr_err) begin
            overflow_next = 1'b0;
        end
        if (rd_en && empty_reg) begin
            underflow_next = 1'b1;
        end else if (clr_err) begin
            underflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            empty_reg        <= 1'b1;
            full_reg         <= 1'b0;
            almost_full_reg  <= (AF_THRESH == 0);
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            // Flags come from count_next so they move on the same edge as count.
            empty_reg        <= (count_next == '0);
            full_reg         <= (count_next == DEPTH_C);
            almost_full_reg  <= (count_next >= AF_C);
            almost_empty_reg <= (count_next <= AE_C);
            overflow_reg     <= overflow_next;
            underflow_reg    <= underflow_next;
        end
    end

    fifo_mem #(
        .WIDTH  (FIFO_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (data_in),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    if (FWFT == int'(RD_FWFT)) begin : g_fwft
        // Head word is shown combinationally; forced to zero while empty so
        // stale memory contents never leak out.
        assign data_out = empty_reg ? '0 : rd_data;
    end else begin : g_reg
        logic [FIFO_WIDTH-1:0] data_out_reg;

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                data_out_reg <= '0;
            end else if (rd_acc) begin
                data_out_reg <= rd_data;
            end
        end

        assign data_out = data_out_reg;
    end

    assign empty        = empty_reg;
    assign full         = full_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed self-checking bench for sync_fifo_ctrl.
// u_reg runs with registered reads (FWFT=0), u_fwft with first-word-fall-through.
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instance
    logic        rst0 = 1'b0;
    logic        wr0 = 1'b0, rd0 = 1'b0, clr0 = 1'b0;
    logic [31:0] din0 = '0;
    logic [31:0] dout0;
    logic        empty0, full0, af0, ae0, ov0, uf0;
    logic [5:0]  count0;

    // FWFT instance
    logic        rst1 = 1'b0;
    logic        wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
    logic [31:0] din1 = '0;
    logic [31:0] dout1;
    logic        empty1, full1, af1, ae1, ov1, uf1;
    logic [5:0]  count1;

    sync_fifo_ctrl #(
        .FIFO_WIDTH (32), .FIFO_DEPTH (DEPTH), .AF_THRESH (AF), .AE_THRESH (AE), .FWFT (0)
    ) u_reg (
        .clk (clk), .rstN (rst0), .wr_en (wr0), .data_in (din0), .rd_en (rd0),
        .clr_err (clr0), .data_out (dout0), .empty (empty0), .full (full0),
        .almost_full (af0), .almost_empty (ae0), .count (count0),
        .overflow (ov0), .underflow (uf0)
    );

    sync_fifo_ctrl #(
        .FIFO_WIDTH (32), .FIFO_DEPTH (DEPTH), .AF_THRESH (AF), .AE_THRESH (AE), .FWFT (1)
    ) u_fwft (
        .clk (clk), .rstN (rst1), .wr_en (wr1), .data_in (din1), .rd_en (rd1),
        .clr_err (clr1), .data_out (dout1), .empty (empty1), .full (full1),
        .almost_full (af1), .almost_empty (ae1), .count (count1),
        .overflow (ov1), .underflow (uf1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model for u_reg
    logic [31:0] m_q[$];
    logic [31:0] m_dout = '0;
    logic        m_ov = 1'b0;
    logic        m_uf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on u_reg with full model update and status check.
    task automatic drive(input logic w, input logic r, input logic [31:0] d, input logic c);
        logic w_acc, r_acc;
        w_acc = w && (m_q.size() < DEPTH);
        r_acc = r && (m_q.size() != 0);
        if (w && !w_acc) m_ov = 1'b1;
        else if (c)      m_ov = 1'b0;
        if (r && !r_acc) m_uf = 1'b1;
        else if (c)      m_uf = 1'b0;
        if (r_acc) m_dout = m_q.pop_front();
        if (w_acc) m_q.push_back(d);
        wr0 = w; rd0 = r; din0 = d; clr0 = c;
        step();
        wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
        $display("txn w=%0b r=%0b c=%0b d=%h -> count=%0d dout=%h ov=%0b uf=%0b",
                 w, r, c, d, count0, dout0, ov0, uf0);
        chk("count", count0, m_q.size());
        chk("empty", empty0, m_q.size() == 0);
        chk("full", full0, m_q.size() == DEPTH);
        chk("almost_full", af0, m_q.size() >= AF);
        chk("almost_empty", ae0, m_q.size() <= AE);
        chk("overflow", ov0, m_ov);
        chk("underflow", uf0, m_uf);
        chk("data_out", dout0, m_dout);
    endtask

    initial begin
        // ---------------- reset then idle ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_low_count", count0, 0);
        chk("rst_low_empty", empty0, 1);
        rst0 = 1'b1;
        rst1 = 1'b1;
        step();
        chk("rst_empty", empty0, 1);
        chk("rst_ae", ae0, 1);
        chk("rst_af", af0, 0);
        chk("rst_full", full0, 0);
        chk("rst_count", count0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_ov", ov0, 0);
        chk("rst_uf", uf0, 0);
        chk("rst_fwft_dout", dout1, 0);
        chk("rst_fwft_empty", empty1, 1);

        // ---------------- fill to full ----------------
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 32'(i), 1'b0);
            if (i == AF - 2) chk("af_before_28", af0, 0);
            if (i == AF - 1) chk("af_at_28", af0, 1);
        end
        chk("full_at_32", full0, 1);
        drive(1'b1, 1'b0, 32'h99, 1'b0);
        chk("ov_33rd_write", ov0, 1);
        chk("count_stays_32", count0, 32);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("ov_cleared", ov0, 0);

        // ---------------- drain, registered read ----------------
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b0);
            chk("drain_data", dout0, 32'(i));
        end
        chk("drain_empty", empty0, 1);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        chk("uf_extra_read", uf0, 1);
        chk("dout_holds", dout0, 31);
        drive(1'b0, 1'b0, 32'h0, 1'b1);

        // ---------------- wrap: pointers cross DEPTH-1 -> 0 ----------------
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 32'h200 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b0);
            chk("wrap_data", dout0, 32'h200 + 32'(i));
        end

        // ---------------- sustained concurrency at count 10 ----------------
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 32'h300 + 32'(i), 1'b0);
        for (int k = 0; k < 50; k++) begin
            drive(1'b1, 1'b1, 32'h400 + 32'(k), 1'b0);
            chk("conc_count10", count0, 10);
        end
        chk("conc_last_data", dout0, 32'h400 + 32'd39);

        // ---------------- full with simultaneous wr/rd ----------------
        for (int i = 0; i < 22; i++) drive(1'b1, 1'b0, 32'h500 + 32'(i), 1'b0);
        chk("refull", full0, 1);
        drive(1'b1, 1'b1, 32'hDEAD, 1'b0);
        chk("full_both_count", count0, 31);
        chk("full_both_ov", ov0, 1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 32'h600, 1'b0);
        drive(1'b1, 1'b0, 32'hBAD, 1'b1);
        chk("clr_vs_new_ov", ov0, 1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("ov_clr_alone", ov0, 0);

        // ---------------- empty with simultaneous wr/rd ----------------
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 32'h0, 1'b0);
        chk("reempty", empty0, 1);
        drive(1'b1, 1'b1, 32'h777, 1'b0);
        chk("empty_both_count", count0, 1);
        chk("empty_both_uf", uf0, 1);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        chk("empty_both_data", dout0, 32'h777);

        // ---------------- FWFT instance ----------------
        chk("fwft_idle_dout", dout1, 0);
        wr1 = 1'b1; din1 = 32'hA5A5_0001;
        step();
        wr1 = 1'b0;
        $display("txn fwft write A5A50001 -> dout=%h empty=%0b", dout1, empty1);
        chk("fwft_first_word", dout1, 32'hA5A5_0001);
        chk("fwft_not_empty", empty1, 0);
        rd1 = 1'b1;
        step();
        rd1 = 1'b0;
        $display("txn fwft read -> dout=%h empty=%0b", dout1, empty1);
        chk("fwft_rd_empty", empty1, 1);
        chk("fwft_rd_dout0", dout1, 0);
        for (int i = 0; i < 3; i++) begin
            wr1 = 1'b1; din1 = 32'hC000 + 32'(i);
            step();
            $display("txn fwft write %h -> count=%0d", din1, count1);
        end
        wr1 = 1'b0;
        chk("fwft_head", dout1, 32'hC000);
        rd1 = 1'b1;
        step();
        rd1 = 1'b0;
        $display("txn fwft read -> dout=%h", dout1);
        chk("fwft_advance", dout1, 32'hC001);
        chk("fwft_count", count1, 2);
        #2;
        rst1 = 1'b0;
        #1;
        $display("txn fwft async reset -> count=%0d dout=%h empty=%0b", count1, dout1, empty1);
        chk("fwft_async_count", count1, 0);
        chk("fwft_async_empty", empty1, 1);
        chk("fwft_async_dout", dout1, 0);
        chk("fwft_async_ae", ae1, 1);
        chk("fwft_async_ov", ov1, 0);
        chk("fwft_async_uf", uf1, 0);
        step();
        rst1 = 1'b1;
        wr1 = 1'b1; din1 = 32'hBEEF;
        step();
        wr1 = 1'b0;
        $display("txn fwft write BEEF after reset -> dout=%h count=%0d", dout1, count1);
        chk("fwft_post_rst_data", dout1, 32'hBEEF);
        chk("fwft_post_rst_count", count1, 1);
        chk("fwft_full", full1, 0);
        chk("fwft_af", af1, 0);
        chk("fwft_clr_unused", clr1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
